// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB-first through an
// external single-bit full adder and assembles the WIDTH-bit result.
//
// state | meaning
// IDLE  | waiting for start; fa_* driven low
// RUN   | one bit pair per cycle presented to the full adder
// DONE  | result valid, done high for this single cycle
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_c
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  assign busy   = (state != IDLE);
  assign fa_a   = (state == RUN) & a_sh[0];
  assign fa_b   = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          s_sh    <= {fa_sum, s_sh[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry_q <= fa_c;
          cnt     <= cnt + 1'b1;
          // last bit: publish the whole result at once so sum never shows partials
          if (cnt == LAST) begin
            sum   <= {fa_sum, s_sh[WIDTH-1:1]};
            cout  <= fa_c;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a mux-style full adder on
// the fa_* ports and a scoreboard of expected {cout,sum} values.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_c;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit b2b = 1'b0;
  bit b2b_prev = 1'b0;
  logic [W:0] q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // mux-based full adder: propagate selects between carry-in and b
  logic fa_p;
  assign fa_p   = fa_a ^ fa_b;
  assign fa_sum = fa_p ? ~fa_cin : fa_cin;
  assign fa_c   = fa_p ? fa_cin : fa_b;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_c(fa_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, e[W]});
      end
      if (b2b && b2b_prev) check("done_period", cyc - last_done_cyc, 32'd10);
      b2b_prev = b2b;
      last_done_cyc = cyc;
    end
  end

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
    int lat;
    @(negedge clk);
    a = oa; b = ob; cin = oc; start = 1'b1;
    q.push_back(model(oa, ob, oc));
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'd8);
    @(posedge clk); #1;
    check("done_fall", {31'd0, done}, 32'd0);
    check("busy_fall", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, d0;
    // 1. reset with random inputs
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
    end
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2. basic add and hold
    do_op(8'h3C, 8'h5A, 1'b0);
    repeat (20) begin
      @(negedge clk);
      check("sum_hold", {24'd0, sum}, 32'h96);
    end

    // 3. carry chain
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h00, 8'h00, 1'b1);

    // 4. start ignored during RUN and DONE
    d0 = n_done;
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
    q.push_back(model(8'h3C, 8'h5A, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_done_seen", {31'd0, done}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("ign_sum", {24'd0, sum}, 32'h96);
    check("ign_done_count", n_done - d0, 32'd1);
    check("ign_busy", {31'd0, busy}, 32'd0);

    // 5. reset on the third RUN cycle
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sum", {24'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);
    do_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    check("post_rst_sum", {24'd0, sum}, 32'h30);

    // 6. back-to-back with start held high
    b2b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      @(negedge clk);
      a = ra; b = rb; cin = rc; start = 1'b1;
      q.push_back(model(ra, rb, rc));
      @(posedge clk);
      repeat (9) @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    b2b = 1'b0;
    check("b2b_drained", q.size(), 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
